// File: rtl/l2_line_responder.sv
// l2_line_responder
//   Responder end of the line-wide L2 request interface. Accepts one
//   128-bit line read or write at a time and serves it as eight sequential
//   16-bit beats to physical memory. When the line is done it returns
//   mem_rdata together with a one-cycle mem_resp pulse.
//
// Ports
//   clk, reset_n      : clock; asynchronous active-low reset
//   mem_address       : line address; bits [3:0] are ignored
//   mem_read/write    : line request, held until mem_resp (write wins)
//   mem_wdata         : write line, held with mem_write
//   mem_rdata         : registered read line, valid with mem_resp
//   mem_resp          : one-cycle completion pulse
//   pmem_address      : beat address {line[15:4], beat[2:0], 1'b0}
//   pmem_read/write   : beat strobes, mutually exclusive
//   pmem_wdata        : beat write data, slot [beat] of mem_wdata
//   pmem_rdata        : beat read data, sampled with pmem_resp
//   pmem_resp         : beat accepted/complete
//
// Build option
//   L2_LINE_BUF_EN : adds a one-line read buffer. A read that hits the
//                    buffer in IDLE completes in one cycle with no pmem
//                    traffic.

module l2_line_responder (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_wdata,
  input  logic [15:0]  pmem_rdata,
  input  logic         pmem_resp
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned BEAT_W = 3;
  localparam int unsigned OFS_W  = 4;
  localparam int unsigned TAG_W  = WORD_W - OFS_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [TAG_W-1:0]    line_q, line_d;
  logic [LINE_W-1:0]   asm_q, asm_d;
  logic [LINE_W-1:0]   rdata_d;
  logic                resp_d;
  logic                rd_d;
  logic                wr_d;
  logic [WORD_W-1:0]   addr_d;
  logic [WORD_W-1:0]   wdata_d;
  logic                last_beat;
  logic                unused_ofs;

`ifdef L2_LINE_BUF_EN
  logic                buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]    buf_tag_q, buf_tag_d;
  logic [LINE_W-1:0]   buf_data_q, buf_data_d;
  logic                buf_hit;
  logic                buf_wr_match;

  // IDLE lookup uses the live address; write update uses the latched line.
  assign buf_hit      = buf_valid_q && (buf_tag_q == mem_address[WORD_W-1:OFS_W]);
  assign buf_wr_match = buf_valid_q && (buf_tag_q == line_q);
`endif

  // Offset bits select nothing: the responder always moves whole lines.
  assign unused_ofs = ^mem_address[OFS_W-1:0];

  assign last_beat = (beat_q == BEAT_W'(7));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, datapath next values and next registered outputs.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    asm_d   = asm_q;
    rdata_d = mem_rdata;
`ifdef L2_LINE_BUF_EN
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
`endif

    case (state_q)
      IDLE: begin
        if (mem_write) begin
          line_d  = mem_address[WORD_W-1:OFS_W];
          beat_d  = '0;
          state_d = WRITE;
        end else if (mem_read) begin
          line_d  = mem_address[WORD_W-1:OFS_W];
          beat_d  = '0;
          state_d = READ;
`ifdef L2_LINE_BUF_EN
          if (buf_hit) begin
            state_d = RESP;
            rdata_d = buf_data_q;
          end
`endif
        end
      end

      READ: begin
        if (pmem_resp) begin
          asm_d[{beat_q, 4'b0000} +: WORD_W] = pmem_rdata;
          // Wraps 7->0 on the final beat, which is also the exit.
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            state_d = RESP;
            rdata_d = asm_d;
`ifdef L2_LINE_BUF_EN
            buf_valid_d = 1'b1;
            buf_tag_d   = line_q;
            buf_data_d  = asm_d;
`endif
          end
        end
      end

      WRITE: begin
        if (pmem_resp) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            state_d = RESP;
`ifdef L2_LINE_BUF_EN
            // Keep the buffer coherent with the line just written.
            if (buf_wr_match) begin
              buf_data_d = mem_wdata;
            end
`endif
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they follow the state being entered.
    resp_d  = (state_d == RESP);
    rd_d    = (state_d == READ);
    wr_d    = (state_d == WRITE);
    addr_d  = (rd_d || wr_d) ? {line_d, beat_d, 1'b0} : '0;
    wdata_d = wr_d ? mem_wdata[{beat_d, 4'b0000} +: WORD_W] : '0;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_q       <= '0;
      line_q       <= '0;
      asm_q        <= '0;
      mem_rdata    <= '0;
      mem_resp     <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      beat_q       <= beat_d;
      line_q       <= line_d;
      asm_q        <= asm_d;
      mem_rdata    <= rdata_d;
      mem_resp     <= resp_d;
      pmem_read    <= rd_d;
      pmem_write   <= wr_d;
      pmem_address <= addr_d;
      pmem_wdata   <= wdata_d;
    end
  end

`ifdef L2_LINE_BUF_EN
  // One-line read buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_l2_line_responder.sv
// Testbench for l2_line_responder: directed vector table, reset-abort
// sequence and randomized line traffic against a line-level reference.
module tb_l2_line_responder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_wdata;
  logic [15:0]  pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  l2_line_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

`ifdef L2_LINE_BUF_EN
  localparam bit BUF_ON = 1'b1;
`else
  localparam bit BUF_ON = 1'b0;
`endif
  localparam int HIT_LAT = BUF_ON ? 1 : 9;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    int           wt;
    int           exp_lat;
    logic [127:0] exp_rdata;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model state and per-transaction observations.
  int          wait_cfg = 0;
  int          wcnt = 0;
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  int          both_cyc = 0;
  logic [15:0] addr_log[$];
  logic [15:0] wd_log[$];
  logic [15:0] pmem_mem[32768];

  // Reference: line contents, buffer occupancy and last returned line.
  logic [15:0]  ref_mem[32768];
  bit           buf_valid = 1'b0;
  logic [11:0]  buf_tag = '0;
  logic [127:0] last_rdata = '0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] wslot(input logic [127:0] w, input int k);
    logic [127:0] t;
    t = w >> (k * 16);
    return t[15:0];
  endfunction

  // One clock: wait for the falling edge, then play memory for that cycle.
  task automatic tick();
    @(negedge clk);
    if (pmem_read) rd_cyc++;
    if (pmem_write) wr_cyc++;
    if (pmem_read && pmem_write) both_cyc++;
    if (pmem_read || pmem_write) begin
      if (wcnt >= wait_cfg) begin
        pmem_resp = 1'b1;
        pmem_rdata = pmem_read ? pmem_mem[pmem_address[15:1]] : 16'($urandom);
        if (pmem_write) begin
          pmem_mem[pmem_address[15:1]] = pmem_wdata;
          wd_log.push_back(pmem_wdata);
        end
        addr_log.push_back(pmem_address);
        wcnt = 0;
      end else begin
        pmem_resp = 1'b0;
        pmem_rdata = 16'($urandom);
        wcnt++;
      end
    end else begin
      pmem_resp = 1'b0;
      pmem_rdata = 16'($urandom);
      wcnt = 0;
    end
  endtask

  // Run one line transaction and check it against the reference.
  task automatic check_txn(input string nm, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [127:0] wd,
                           input int wt, input bit scramble,
                           output int lat, output logic [127:0] rdata);
    bit           is_w, is_r, hit;
    logic [11:0]  line;
    int           exp_lat;
    int           nb;
    logic [127:0] exp_line;
    logic         resp_after;

    is_w = wr;
    is_r = rd && !wr;
    line = addr[15:4];
    hit = BUF_ON && is_r && buf_valid && (buf_tag == line);
    exp_lat = hit ? 1 : 1 + 8 * (wt + 1);
    exp_line = '0;
    for (int k = 7; k >= 0; k--) exp_line = {exp_line[111:0], ref_mem[{line, 3'(k)}]};

    wait_cfg = wt;
    wcnt = 0;
    addr_log.delete();
    wd_log.delete();
    rd_cyc = 0;
    wr_cyc = 0;
    both_cyc = 0;
    mem_read = rd;
    mem_write = wr;
    mem_address = addr;
    mem_wdata = wd;
    lat = -1;
    rdata = '0;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (mem_resp) begin
        lat = c;
        rdata = mem_rdata;
        break;
      end
      if (scramble && c == 2) mem_address = 16'($urandom);
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    tick();
    resp_after = mem_resp;

    if (is_r) last_rdata = exp_line;
    if (is_w) for (int k = 0; k < 8; k++) ref_mem[{line, 3'(k)}] = wslot(wd, k);
    if (is_r && !hit) begin
      buf_valid = 1'b1;
      buf_tag = line;
    end

    nb = hit ? 0 : 8;
    check({nm, " latency"}, 128'(lat), 128'(exp_lat));
    check({nm, " rdata"}, rdata, last_rdata);
    check({nm, " beats"}, 128'(addr_log.size()), 128'(nb));
    for (int k = 0; k < addr_log.size() && k < 8; k++)
      check($sformatf("%s addr%0d", nm, k), 128'(addr_log[k]), 128'({line, 3'(k), 1'b0}));
    if (is_w)
      for (int k = 0; k < wd_log.size() && k < 8; k++)
        check($sformatf("%s wdata%0d", nm, k), 128'(wd_log[k]), 128'(wslot(wd, k)));
    check({nm, " rd_strobe_cycles"}, 128'(rd_cyc), 128'((is_r && !hit) ? exp_lat - 1 : 0));
    check({nm, " wr_strobe_cycles"}, 128'(wr_cyc), 128'(is_w ? exp_lat - 1 : 0));
    check({nm, " both_strobes"}, 128'(both_cyc), 128'(0));
    check({nm, " resp_one_cycle"}, 128'(resp_after), 128'(0));
  endtask

  initial begin
    vec_t         tbl[7];
    int           lat;
    int           guard;
    int           r;
    logic [127:0] rdv;
    logic [127:0] w;
    logic [15:0]  a;
    logic         rdx, wrx;

    reset_n = 1'b0;
    mem_address = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    for (int i = 0; i < 32768; i++) begin
      pmem_mem[i] = 16'(i * 40503) ^ 16'h5A5A;
      ref_mem[i] = pmem_mem[i];
    end
    for (int k = 0; k < 8; k++) begin
      pmem_mem[{12'h123, 3'(k)}] = 16'hA000 + 16'(k);
      ref_mem[{12'h123, 3'(k)}] = 16'hA000 + 16'(k);
    end

    repeat (3) @(negedge clk);
    check("in_reset outputs", 128'({mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata}), '0);
    check("in_reset rdata", mem_rdata, '0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("idle%0d outputs", i),
            128'({mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata}), '0);
    end
    check("idle rdata", mem_rdata, '0);

    tbl[0] = '{1'b1, 1'b0, 16'h1234, '0, 0, 9, 128'hA007A006A005A004A003A002A001A000};
    tbl[1] = '{1'b1, 1'b0, 16'h1234, '0, 0, HIT_LAT, 128'hA007A006A005A004A003A002A001A000};
    tbl[2] = '{1'b0, 1'b1, 16'h2000, 128'h55075506550555045503550255015500, 2, 25,
               128'hA007A006A005A004A003A002A001A000};
    tbl[3] = '{1'b1, 1'b1, 16'h3000, 128'h0123456789ABCDEF0F1E2D3C4B5A6978, 0, 9,
               128'hA007A006A005A004A003A002A001A000};
    tbl[4] = '{1'b0, 1'b1, 16'h1230, 128'hC007C006C005C004C003C002C001C000, 0, 9,
               128'hA007A006A005A004A003A002A001A000};
    tbl[5] = '{1'b1, 1'b0, 16'h1234, '0, 0, HIT_LAT, 128'hC007C006C005C004C003C002C001C000};
    tbl[6] = '{1'b1, 1'b0, 16'h2008, '0, 1, 17, 128'h55075506550555045503550255015500};

    for (int i = 0; i < 7; i++) begin
      check_txn($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                tbl[i].wt, 1'b0, lat, rdv);
      check($sformatf("vec%0d table_latency", i), 128'(lat), 128'(tbl[i].exp_lat));
      check($sformatf("vec%0d table_rdata", i), rdv, tbl[i].exp_rdata);
    end

    // Reset asserted while beat 4 of a read is in flight.
    wait_cfg = 0;
    wcnt = 0;
    addr_log.delete();
    mem_read = 1'b1;
    mem_address = 16'h4000;
    guard = 0;
    while (addr_log.size() < 5 && guard < 40) begin
      tick();
      guard++;
    end
    check("rst reached_beat4", 128'(addr_log.size()), 128'(5));
    #2 reset_n = 1'b0;
    #1;
    check("rst async_strobes", 128'({mem_resp, pmem_read, pmem_write}), '0);
    check("rst async_addr", 128'(pmem_address), '0);
    mem_read = 1'b0;
    pmem_resp = 1'b0;
    wcnt = 0;
    buf_valid = 1'b0;
    last_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("post_rst%0d quiet", i), 128'({mem_resp, pmem_read, pmem_write}), '0);
    end
    check("post_rst rdata", mem_rdata, '0);
    check_txn("after_rst", 1'b1, 1'b0, 16'h4000, '0, 0, 1'b0, lat, rdv);
    check("after_rst latency_abs", 128'(lat), 128'(9));

    // Randomized traffic over a few lines so buffer hits and overwrites occur.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 3));
      rdx = (r != 2);
      wrx = (r >= 2);
      a = {12'h100 + 12'($urandom_range(0, 3)), 4'($urandom)};
      w = {$urandom, $urandom, $urandom, $urandom};
      check_txn($sformatf("rnd%0d", n), rdx, wrx, a, w, int'($urandom_range(0, 2)), 1'b1, lat, rdv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_line_responder.md
# l2_line_responder

Responder end of the line-wide L2 request interface. Sits below the I/D cache arbiter datapath and accepts one 128-bit line read or write at a time (`mem_address`, `mem_read`, `mem_write`, `mem_wdata`). It serves each request as eight sequential 16-bit beats to physical memory, then returns `mem_rdata` and a one-cycle `mem_resp` pulse.

## Interface
Parameters:
- none; widths follow `lc3b_word` (16) and `lc3b_line` (128).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `mem_address` in 16: line request address; bits [3:0] are ignored.
- `mem_read` in 1: line read request; held by the requester until `mem_resp`.
- `mem_write` in 1: line write request; held by the requester until `mem_resp`.
- `mem_wdata` in 128: write line; held with `mem_write`.
- `mem_rdata` out 128: registered read line; valid while `mem_resp`=1.
- `mem_resp` out 1: one-cycle completion pulse.
- `pmem_address` out 16: beat address `{line[15:4], beat[2:0], 1'b0}`.
- `pmem_read` out 1: beat read request.
- `pmem_write` out 1: beat write request.
- `pmem_wdata` out 16: beat write data, taken from `mem_wdata[16*beat+15 : 16*beat]`.
- `pmem_rdata` in 16: beat read data; sampled on the cycle where `pmem_resp`=1.
- `pmem_resp` in 1: beat accepted/complete.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - On `mem_write`: latch `mem_address[15:4]`, clear the beat counter, go to WRITE. Write has priority if `mem_read` and `mem_write` are both high; the read is ignored for that transaction.
  - On `mem_read` only: latch the address, clear the counter, go to READ (see Configuration for the hit path).
- READ: `pmem_read`=1.
  - On each `pmem_resp`: write `pmem_rdata` into line slot [beat] and increment beat.
  - On `pmem_resp` with beat=7: go to RESP.
- WRITE: `pmem_write`=1 and `pmem_wdata` = slot [beat] of `mem_wdata`.
  - Beat advance is the same as READ; beat 7 `pmem_resp` goes to RESP.
- RESP: `mem_resp`=1 for exactly one cycle, then IDLE.
  - A request still asserted in the following IDLE cycle is treated as a new transaction.
- The beat counter is 3 bits; it wraps 7→0 only on the exit transition.
- `pmem_read` and `pmem_write` are never high together, and both are 0 outside READ/WRITE.
- The requester must not change address, data or request type mid-transaction. The latched address is used, so changes do not affect the transaction.
- Reset values: `mem_resp`=0, `mem_rdata`=0, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, state=IDLE, beat=0.
- Reset mid-transaction aborts it immediately (asynchronously). No `mem_resp` is issued.

## Timing
- Request sampled in IDLE at cycle 0. `pmem_*` asserts from cycle 1.
- `pmem_address` updates in the cycle after each `pmem_resp`. The request strobe stays high across beats.
- With zero-wait memory (`pmem_resp` high every cycle), `mem_resp` pulses in cycle 9. Each wait cycle on any beat adds one.
- `mem_rdata` is stable from the RESP cycle until the next read completes.

## Configuration
- `L2_LINE_BUF_EN` defined: keep a one-line read buffer (valid bit, tag = addr[15:4], 128-bit data).
  - Buffer fill: a completed pmem read loads it.
  - Read hit: an IDLE read whose tag matches a valid buffer goes straight to RESP. `mem_resp` pulses in cycle 1 with no pmem traffic.
  - Write to the buffered tag: the buffer is updated with `mem_wdata` when that write's RESP occurs.
  - Reset clears valid.
- `L2_LINE_BUF_EN` undefined: no buffer exists, and every read performs 8 beats.

## Test plan
- Reset then idle: all outputs 0 and no pmem strobes for 20 cycles.
- Read 0x1234, zero-wait memory returning beat k = 0xA000+k:
  - `pmem_address` steps 0x1230, 0x1232 … 0x123E.
  - `mem_resp` pulses in cycle 9.
  - `mem_rdata` = {0xA007 … 0xA000}.
- Write 0x2000 with line word k = 0x5500+k, `pmem_resp` delayed 2 cycles per beat:
  - `pmem_wdata` sequence 0x5500…0x5507 is observed.
  - `mem_resp` pulses in cycle 25.
- `mem_read` and `mem_write` both high: only `pmem_write` toggles, and one `mem_resp` is issued.
- `reset_n` pulled low during beat 4 of a read: strobes drop asynchronously, no `mem_resp`; the next read completes normally.
- With `L2_LINE_BUF_EN` defined:
  - Second read of 0x1234: `mem_resp` in cycle 1, zero pmem strobes.
  - Write 0x1230 then read 0x1234: the read returns the write data.
